// File: rtl/hazard_forward_unit.sv
// Operand bypass from EX/MEM/WB and a short retired-write history onto the ID read ports.
// Also raises a load-use stall of LOAD_LAT cycles and keeps a saturating count of stalled cycles.
module hazard_forward_unit #(
   parameter int XLEN       = 32,
   parameter int NPORT      = 2,
   parameter int HIST_DEPTH = 2,
   parameter int LOAD_LAT   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NPORT*5-1:0]      rd_addr,
   input  logic [NPORT*XLEN-1:0]   rf_data,
   output logic [NPORT*XLEN-1:0]   fwd_data,
   input  logic                    ex_valid,
   input  logic                    ex_we,
   input  logic                    ex_is_load,
   input  logic [4:0]              ex_waddr,
   input  logic [XLEN-1:0]         ex_wdata,
   input  logic                    mem_valid,
   input  logic                    mem_we,
   input  logic [4:0]              mem_waddr,
   input  logic [XLEN-1:0]         mem_wdata,
   input  logic                    wb_valid,
   input  logic                    wb_we,
   input  logic [4:0]              wb_waddr,
   input  logic [XLEN-1:0]         wb_wdata,
   input  logic                    flush,
   output logic                    stall,
   output logic [31:0]             stall_cycles
);

   localparam int         HD       = (HIST_DEPTH > 0) ? HIST_DEPTH : 1;
   localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

   logic            ex_fwd;
   logic            ex_ld;
   logic            mem_wr;
   logic            wb_wr;
   logic            any_ld_match;
   logic            ld_hit;
   logic [1:0]      cnt;

   logic [HD-1:0]   h_v;
   logic [4:0]      h_a [HD];
   logic [XLEN-1:0] h_d [HD];

   assign ex_fwd = ex_valid & ex_we & ~ex_is_load & (ex_waddr != 5'd0);
   assign ex_ld  = ex_valid & ex_we &  ex_is_load & (ex_waddr != 5'd0);
   assign mem_wr = mem_valid & mem_we & (mem_waddr != 5'd0);
   assign wb_wr  = wb_valid & wb_we & (wb_waddr != 5'd0);

   // Retired writes are architectural state, so flush leaves the history alone.
   generate
      if (HIST_DEPTH > 0) begin : g_hist
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               h_v <= '0;
               for (int i = 0; i < HD; i++) begin
                  h_a[i] <= '0;
                  h_d[i] <= '0;
               end
            end else if (wb_wr) begin
               h_v[0] <= 1'b1;
               h_a[0] <= wb_waddr;
               h_d[0] <= wb_wdata;
               for (int i = 1; i < HD; i++) begin
                  h_v[i] <= h_v[i-1];
                  h_a[i] <= h_a[i-1];
                  h_d[i] <= h_d[i-1];
               end
            end
         end
      end else begin : g_no_hist
         assign h_v    = '0;
         assign h_a[0] = '0;
         assign h_d[0] = '0;
      end
   endgenerate

   always_comb begin
      logic [4:0] a;
      a        = '0;
      fwd_data = rf_data;
      for (int p = 0; p < NPORT; p++) begin
         a = rd_addr[5*p +: 5];
         if (a != 5'd0) begin
            if (ex_fwd && ex_waddr == a) begin
               fwd_data[XLEN*p +: XLEN] = ex_wdata;
            end else if (mem_wr && mem_waddr == a) begin
               fwd_data[XLEN*p +: XLEN] = mem_wdata;
            end else if (wb_wr && wb_waddr == a) begin
               fwd_data[XLEN*p +: XLEN] = wb_wdata;
            end else begin
               // Walk oldest to newest so the newest matching entry wins.
               for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
                  if (h_v[i] && h_a[i] == a) begin
                     fwd_data[XLEN*p +: XLEN] = h_d[i];
                  end
               end
            end
         end
      end
   end

   always_comb begin
      any_ld_match = 1'b0;
      for (int p = 0; p < NPORT; p++) begin
         if (rd_addr[5*p +: 5] == ex_waddr) begin
            any_ld_match = 1'b1;
         end
      end
   end

   assign ld_hit = ex_ld & any_ld_match & ~flush;

   // First stall cycle is combinational; cnt covers the remaining LOAD_LAT-1 cycles.
   assign stall = rst_n & ~flush & ((cnt != 2'd0) | ld_hit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 2'd0;
      end else if (flush) begin
         cnt <= 2'd0;
      end else if (cnt != 2'd0) begin
         cnt <= cnt - 2'd1;
      end else if (ld_hit) begin
         cnt <= CNT_INIT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stall && stall_cycles != 32'hFFFF_FFFF) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule
